// File: rtl/usart_tx_feeder_if.sv
// usart_tx_feeder_if: producer-side and transmitter-side signals of the byte feeder.
// The master modport is the environment (producer + transmitter); the slave modport is the feeder.
interface usart_tx_feeder_if #(
  parameter int unsigned AW = 4
) ();
  logic          enable;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          overflow;
  logic          timeout_err;
  logic          clr_err;
  logic [15:0]   sent_count;

  modport master (
    output enable, wr_en, wr_data, tx_busy, clr_err,
    input  full, empty, level, tx_data, tx_start, overflow, timeout_err, sent_count
  );

  modport slave (
    input  enable, wr_en, wr_data, tx_busy, clr_err,
    output full, empty, level, tx_data, tx_start, overflow, timeout_err, sent_count
  );
endinterface

// File: rtl/usart_tx_feeder.sv
// usart_tx_feeder: FIFO-buffered byte feeder for a UART transmitter.
// Drains one byte per start/busy handshake with a programmable inter-byte gap and a
// busy-rise timeout. Optional CR/LF terminator after the FIFO drains is built only
// when USART_TX_FEEDER_CRLF_EN is defined.
module usart_tx_feeder #(
  parameter int unsigned AW           = 4,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  usart_tx_feeder_if.slave   io_bus
);

  localparam int unsigned DEPTH   = 2**AW;
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned TMR_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TW      = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic            r_full;
  logic            r_empty;

  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic            r_overflow;
  logic            r_timeout_err;
  logic [15:0]     r_sent_count;

  logic            w_pop;
  logic            w_load;
  logic            w_sent_inc;
  logic            w_timeout_set;
  logic            w_wr_ok;
  logic            w_ovf_set;
  logic [7:0]      w_load_data;

`ifdef USART_TX_FEEDER_CRLF_EN
  typedef enum logic [1:0] {
    T_NONE,
    T_CR,
    T_LF
  } term_t;

  term_t           r_term;
  term_t           w_term_nxt;
  logic            r_crlf_due;
  logic            w_crlf_due_nxt;
`endif

  // FSM state register (plus terminator tracking when built)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
`ifdef USART_TX_FEEDER_CRLF_EN
      r_term     <= T_NONE;
      r_crlf_due <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
`ifdef USART_TX_FEEDER_CRLF_EN
      r_term     <= w_term_nxt;
      r_crlf_due <= w_crlf_due_nxt;
`endif
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_sent_inc    = 1'b0;
    w_timeout_set = 1'b0;
`ifdef USART_TX_FEEDER_CRLF_EN
    w_term_nxt     = r_term;
    w_crlf_due_nxt = r_crlf_due;
`endif
    case (r_state)
      S_IDLE: begin
        if (io_bus.enable && !r_empty) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load      = 1'b1;
`ifdef USART_TX_FEEDER_CRLF_EN
        w_pop       = (r_term == T_NONE);
`else
        w_pop       = 1'b1;
`endif
        w_state_nxt = S_START;
      end
      S_START: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (io_bus.tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_timer == BUSY_LAST) begin
          w_timeout_set = 1'b1;
          w_timer_nxt   = '0;
          w_state_nxt   = S_GAP;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!io_bus.tx_busy) begin
          w_sent_inc  = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = S_GAP;
`ifdef USART_TX_FEEDER_CRLF_EN
          w_crlf_due_nxt = (r_term == T_NONE);
`endif
        end
      end
      S_GAP: begin
        if (r_timer == GAP_LAST) begin
`ifdef USART_TX_FEEDER_CRLF_EN
          w_crlf_due_nxt = 1'b0;
          case (r_term)
            T_CR: begin
              w_term_nxt  = T_LF;
              w_state_nxt = S_LOAD;
            end
            T_LF: begin
              w_term_nxt  = T_NONE;
              w_state_nxt = S_IDLE;
            end
            default: begin
              if (r_crlf_due && r_empty) begin
                w_term_nxt  = T_CR;
                w_state_nxt = S_LOAD;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          endcase
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte selected in LOAD: FIFO head, or a terminator when one is in progress
  always_comb begin
    w_load_data = r_mem[r_rd_ptr];
`ifdef USART_TX_FEEDER_CRLF_EN
    if (r_term == T_CR) w_load_data = 8'h0D;
    if (r_term == T_LF) w_load_data = 8'h0A;
`endif
  end

  // FIFO accept/drop decision and next occupancy; a same-cycle pop frees the slot
  always_comb begin
    w_wr_ok   = io_bus.wr_en && (!r_full || w_pop);
    w_ovf_set = io_bus.wr_en && r_full && !w_pop;
    case ({w_wr_ok, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage (contents are don't-care until written)
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= io_bus.wr_data;
  end

  // FIFO pointers, occupancy and flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Transmitter-facing outputs, sticky errors and completed-byte counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sent_count  <= '0;
    end else begin
      if (w_load) r_tx_data <= w_load_data;
      r_tx_start <= (r_state == S_START);
      if (w_ovf_set)           r_overflow <= 1'b1;
      else if (io_bus.clr_err) r_overflow <= 1'b0;
      if (w_timeout_set)       r_timeout_err <= 1'b1;
      else if (io_bus.clr_err) r_timeout_err <= 1'b0;
      if (w_sent_inc) r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign io_bus.full        = r_full;
  assign io_bus.empty       = r_empty;
  assign io_bus.level       = r_level;
  assign io_bus.tx_data     = r_tx_data;
  assign io_bus.tx_start    = r_tx_start;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.timeout_err = r_timeout_err;
  assign io_bus.sent_count  = r_sent_count;

endmodule

// File: tb/tb_usart_tx_feeder.sv
// Testbench for usart_tx_feeder: transmitter model, scoreboard of issued bytes, directed tests.
module tb_usart_tx_feeder;

  localparam int unsigned AW    = 4;
  localparam int unsigned GAP   = 16;
  localparam int unsigned TMO   = 64;
  localparam int unsigned DEPTH = 16;
  localparam int          BUSY_LEN = 20;
`ifdef USART_TX_FEEDER_CRLF_EN
  localparam int NT = 2;
`else
  localparam int NT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  usart_tx_feeder_if #(.AW(AW)) bus ();

  usart_tx_feeder #(
    .AW(AW),
    .GAP_CYCLES(GAP),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_start = -1;
  int n_starts = 0;
  bit spacing_on = 1'b0;
  bit ignore_next = 1'b0;
  int busy_cnt = 0;
  bit rise_pend = 1'b0;
  int exp_sent = 0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy rises one cycle after a start pulse and stays high BUSY_LEN cycles
  always @(negedge clk) begin
    if (reset) begin
      bus.tx_busy = 1'b0;
      busy_cnt = 0;
      rise_pend = 1'b0;
    end else begin
      if (rise_pend) begin
        rise_pend = 1'b0;
        bus.tx_busy = 1'b1;
        busy_cnt = BUSY_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) begin
        if (ignore_next) ignore_next = 1'b0;
        else rise_pend = 1'b1;
      end
    end
  end

  // Monitor: every start pulse must carry the next expected byte
  always @(negedge clk) begin
    if (!reset && bus.tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_start: got byte 0x%0h, expected no start (cycle %0d)", bus.tx_data, cyc);
      end else begin
        check("tx_data_stream", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
      if (spacing_on && last_start >= 0) begin
        n_cmp++;
        if (cyc - last_start < BUSY_LEN + GAP) begin
          n_bad++;
          $display("FAIL start_spacing: got %0d cycles, expected >= %0d", cyc - last_start, BUSY_LEN + GAP);
        end
      end
      last_start = cyc;
    end
  end

  task automatic write_byte(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic push_term();
    if (NT == 2) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    exp_sent += NT;
  endtask

  task automatic wait_sent(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (int'(bus.sent_count) == exp_sent) break;
      @(negedge clk);
    end
    check(name, 32'(bus.sent_count), 32'(exp_sent));
    repeat (GAP + 8) @(negedge clk);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_err = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("rst_sent", 32'(bus.sent_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three bytes, first-byte latency and start spacing
    bus.enable = 1'b1;
    spacing_on = 1'b1;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h41;
    @(negedge clk);
    bus.wr_data = 8'h42;
    @(negedge clk);
    check("lat_tx_data_n1", 32'(bus.tx_data), 32'd0);
    bus.wr_data = 8'h43;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("lat_tx_data_n2", 32'(bus.tx_data), 32'h41);
    check("lat_tx_start_n2", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    check("lat_tx_start_n3", 32'(bus.tx_start), 32'd1);
    exp_sent += 3;
    push_term();
    wait_sent("t1_sent");
    check("t1_empty", 32'(bus.empty), 32'd1);
    spacing_on = 1'b0;

    // Overflow with enable low, then simultaneous write and pop while full
    bus.enable = 1'b0;
    for (int i = 0; i < 17; i++) write_byte(8'(8'h50 + i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h50 + i));
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_level", 32'(bus.level), 32'd16);
    check("t2_overflow", 32'(bus.overflow), 32'd1);
    pulse_clr();
    check("t2_overflow_clr", 32'(bus.overflow), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h61;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t4_level_wr_pop", 32'(bus.level), 32'd16);
    check("t4_full_wr_pop", 32'(bus.full), 32'd1);
    check("t4_no_overflow", 32'(bus.overflow), 32'd0);
    exp_q.push_back(8'h61);
    exp_sent += 17;
    push_term();
    wait_sent("t2_sent");
    check("t2_overflow_end", 32'(bus.overflow), 32'd0);

    // Busy timeout: first byte ignored by the transmitter, second still issued
    bus.enable = 1'b0;
    ignore_next = 1'b1;
    write_byte(8'h71);
    write_byte(8'h72);
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h72);
    bus.enable = 1'b1;
    begin : wait_start
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.tx_start) begin
          seen = 1'b1;
          break;
        end
      end
      check("t3_start_seen", 32'(seen), 32'd1);
    end
    repeat (TMO - 1) @(negedge clk);
    check("t3_timeout_not_yet", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check("t3_timeout_set", 32'(bus.timeout_err), 32'd1);
    exp_sent += 1;
    push_term();
    wait_sent("t3_sent");
    check("t3_timeout_sticky", 32'(bus.timeout_err), 32'd1);
    pulse_clr();
    check("t3_timeout_clr", 32'(bus.timeout_err), 32'd0);

    // Reset mid-byte with five bytes still queued
    bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h81 + i));
    exp_q.push_back(8'h81);
    bus.enable = 1'b1;
    begin : wait_busy
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.tx_busy) begin
          seen = 1'b1;
          break;
        end
      end
      check("t5_busy_seen", 32'(seen), 32'd1);
    end
    repeat (5) @(negedge clk);
    check("t5_level_before", 32'(bus.level), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_level", 32'(bus.level), 32'd0);
    check("t5_rst_empty", 32'(bus.empty), 32'd1);
    check("t5_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("t5_rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("t5_rst_sent", 32'(bus.sent_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_sent = 0;
    begin : quiet_after_reset
      int starts0;
      starts0 = n_starts;
      repeat (200) @(negedge clk);
      check("t5_no_start", 32'(n_starts - starts0), 32'd0);
    end
    check("t5_empty", 32'(bus.empty), 32'd1);
    check("t5_sent", 32'(bus.sent_count), 32'd0);

    // Single byte (followed by CR/LF when the terminator option is built)
    write_byte(8'h48);
    exp_q.push_back(8'h48);
    exp_sent += 1;
    push_term();
    wait_sent("t6_sent");
    check("t6_empty", 32'(bus.empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usart_tx_feeder.md
Name: usart_tx_feeder

Overview:
- Byte-stream feeder that sits directly upstream of the UART transmitter.
- Buffers bytes from a producer (test pattern generator, message logic) in a FIFO.
- Drains the FIFO one byte at a time into the transmitter using a start-pulse / busy handshake, with a programmable inter-byte gap.
- Replaces ad-hoc toggle/delay driving of the transmitter with a cycle-exact, timeout-protected sequencer.

Parameters:
- AW, 4, FIFO address width; depth = 2**AW entries.
- GAP_CYCLES, 16, idle clk cycles after tx_busy falls before the next byte is issued (0 allowed).
- BUSY_TIMEOUT, 64, max clk cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = drain FIFO; 0 = hold after the current byte completes.
- wr_en  in  1  producer write strobe.
- wr_data  in  8  producer byte.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  AW+1  FIFO occupancy, 0..2**AW.
- tx_data  out  8  byte presented to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter shifting (high from frame start to stop bit end).
- overflow  out  1  sticky: write attempted while full.
- timeout_err  out  1  sticky: tx_busy never rose within BUSY_TIMEOUT.
- clr_err  in  1  synchronous clear of both sticky flags.
- sent_count  out  16  bytes completed, wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers = 0, level = 0, empty = 1, full = 0.
  - tx_data = 0, tx_start = 0, overflow = 0, timeout_err = 0, sent_count = 0.
  - FSM = IDLE.
- Reset mid-byte discards that byte and all FIFO contents. Nothing is replayed.
- FIFO:
  - Write accepted when wr_en & !full.
  - wr_en & full: data dropped, overflow set, level unchanged.
  - Pop happens only in the FSM LOAD state.
  - Write and pop in the same cycle: level unchanged; allowed even when full (pop frees the slot).
  - Pointers wrap modulo 2**AW.
- FSM states:
  - IDLE: if enable & !empty -> LOAD.
  - LOAD: tx_data <= FIFO head; pop; -> START.
  - START: tx_start = 1 for exactly this cycle; reset timer; -> WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy = 1 -> WAIT_DONE.
    - Timer reaches BUSY_TIMEOUT-1 with tx_busy still 0 -> set timeout_err, -> GAP. The byte counts as lost and sent_count is not incremented.
  - WAIT_DONE: tx_busy = 0 -> sent_count++, reset timer, -> GAP.
  - GAP: count GAP_CYCLES cycles, then -> IDLE. GAP_CYCLES = 0 means exactly 1 cycle in GAP.
- Latency, empty FIFO with enable high: byte written at cycle N appears on tx_data at N+2 and tx_start pulses at N+3.
- tx_data holds its value from LOAD until the next LOAD.
- enable deasserted mid-byte: the byte in flight completes normally; FSM parks in IDLE.
- clr_err and a new error in the same cycle: the set wins.
- tx_busy already high in START (stale transmitter): WAIT_BUSY sees it on the next cycle and proceeds.

Optional Feature:
- Macro: USART_TX_FEEDER_CRLF_EN.
- Defined:
  - When the FIFO goes empty after a byte completes, the FSM sends 0x0D then 0x0A through the same LOAD/START/WAIT/GAP sequence, then returns to IDLE.
  - CR and LF each increment sent_count.
  - A write arriving during CR/LF is held until LF completes.
- Undefined: no terminator bytes; the CR/LF logic is absent from the netlist.

Test Plan:
- Reset, then write 0x41,0x42,0x43 with a transmitter model (busy 20 cycles, rising 1 cycle after start) -> tx_data 0x41,0x42,0x43 in order; 3 tx_start pulses ≥ 20+GAP_CYCLES apart; sent_count = 3; empty = 1.
- enable = 0, write 17 bytes with AW = 4 -> full = 1, level = 16, overflow = 1, 17th byte absent from transmitted stream; clr_err -> overflow = 0.
- Transmitter model ignores tx_start -> after 64 cycles timeout_err = 1, sent_count unchanged, next byte still issued.
- Write and pop in the same cycle while full -> level stays 16, no overflow, byte order preserved.
- Assert reset mid-WAIT_DONE with 5 bytes queued -> all outputs return to reset values immediately; no further tx_start after release.
- With USART_TX_FEEDER_CRLF_EN defined, write 0x48 -> transmitted 0x48,0x0D,0x0A; sent_count = 3.
